prod_accum: RTL
===============

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter C_WIDTH, default 16: width of the signed product input from the upstream multiplier.
REQ-002 Parameter ACC_LEN, default 4: number of products summed per result; legal values 2..256.
REQ-003 Parameter OUT_WIDTH, default 16: width of the signed result.
REQ-004 Parameter SHIFT, default 2: arithmetic right shift applied to the sum; legal values 0..C_WIDTH.
REQ-005 Localparam ACC_WIDTH SHALL equal C_WIDTH + clog2(ACC_LEN).
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 clr  input  1  synchronous abort of the partial sum.
REQ-010 in_valid  input  1  product beat valid.
REQ-011 in_ready  output  1  block accepts a beat.
REQ-012 in_data  input  C_WIDTH  signed product.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  OUT_WIDTH  signed, rounded and saturated result.
REQ-016 out_sat  output  1  out_data was clipped; qualified by out_valid.

Function
REQ-017 FSM states: ACCUM and HOLD; reset state is ACCUM.
REQ-018 in_ready SHALL be 1 only in ACCUM with clr=0.
REQ-019 A beat is accepted when in_valid and in_ready are both 1; the accumulator adds sign-extended in_data, and a beat counter increments.
REQ-020 On the ACC_LEN-th accepted beat: the final sum is rounded and saturated; out_data and out_sat are registered; the accumulator and counter clear; the FSM enters HOLD.
REQ-021 Latency: out_valid SHALL assert on the cycle after the last beat is accepted.
REQ-022 In HOLD, out_valid=1 and out_data/out_sat are stable until out_valid and out_ready are both 1.
REQ-023 On that out handshake the FSM returns to ACCUM on the next cycle; the next beat is accepted no earlier than one cycle after the handshake.
REQ-024 Rounding: if SHIFT>0, add 2^(SHIFT-1) to the full-width sum, then shift right arithmetically by SHIFT (round half up); if SHIFT=0, pass the sum through unchanged.
REQ-025 Saturation: if the shifted value exceeds the OUT_WIDTH signed range, clip to +max or -min and set out_sat=1; otherwise out_sat=0.
REQ-026 Intermediate rounding arithmetic SHALL use ACC_WIDTH+1 bits, so no internal overflow occurs.
REQ-027 clr=1 in ACCUM: clear the accumulator and counter; any beat presented that cycle is not accepted.
REQ-028 clr=1 in HOLD: no effect; the held result is still delivered.
REQ-029 in_valid deasserting mid-accumulation: state is held indefinitely, with no timeout.

Reset
REQ-030 While rst_n=0: FSM=ACCUM, accumulator=0, counter=0, out_valid=0, out_data=0, out_sat=0, in_ready=0.
REQ-031 Reset asserted mid-accumulation or in HOLD discards all partial and held data.
REQ-032 in_ready rises no earlier than the first clk edge after rst_n deasserts.

Structure
REQ-033 The shared package/header SHALL hold the FSM state encodings and the clog2 constant function.
REQ-034 The rounding and saturation logic SHALL be one combinational sub-module, round_sat, parameterised by input width, OUT_WIDTH and SHIFT.
REQ-035 All registers SHALL be in the single clk domain, with the asynchronous rst_n only.

Verification (C_WIDTH=16, ACC_LEN=4, OUT_WIDTH=16, SHIFT=2 unless stated)
REQ-036 Beats 100, 200, -50, 6 back-to-back -> out_data=64, out_sat=0, out_valid on the cycle after the 4th beat.
REQ-037 Beats 1, 1, 1, 0 -> out_data=1; beats -3, 0, 0, 0 -> out_data=-1 (round half up checked).
REQ-038 SHIFT=0: 4x 32767 -> out_data=32767, out_sat=1; 4x -32768 -> out_data=-32768, out_sat=1.
REQ-039 out_ready held 0 for 10 cycles after out_valid -> out_data stable and in_ready=0 throughout; handshake -> in_ready=1 on the next cycle.
REQ-040 Two beats of 500, then clr=1 with in_valid=1 and 700, then beats 4, 4, 4, 4 -> out_data=4; the 700 is not accepted.
REQ-041 rst_n pulsed low after 3 beats -> all outputs 0 immediately; the following 4 beats of 8 -> out_data=8.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encodings and a
// constant clog2 helper used to size the accumulator and beat counter.
package prod_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prod_accum_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation
// of a full-width sum down to OUT_WIDTH bits.
module round_sat #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 2
) (
  input  logic [IN_WIDTH-1:0]  sum,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);

  // One guard bit keeps the rounding addend from overflowing the sum.
  localparam int W = IN_WIDTH + 1;
  localparam logic signed [W-1:0] RND = W'((64'd1 << SHIFT) >> 1);

  logic signed [W-1:0] rounded;
  logic signed [W-1:0] shifted;

  always_comb begin
    rounded = W'($signed(sum)) + RND;
    shifted = rounded >>> SHIFT;
  end

  generate
    if (OUT_WIDTH < W) begin : g_clip
      localparam logic signed [W-1:0] MAXV = W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
      localparam logic signed [W-1:0] MINV = ~MAXV;

      always_comb begin
        data = shifted[OUT_WIDTH-1:0];
        sat  = 1'b0;
        if (shifted > MAXV) begin
          data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
          sat  = 1'b1;
        end else if (shifted < MINV) begin
          data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
          sat  = 1'b1;
        end
      end
    end else begin : g_wide
      always_comb begin
        data = OUT_WIDTH'(shifted);
        sat  = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/prod_accum.sv
// Sums ACC_LEN signed products from the upstream multiplier, then rounds,
// saturates and holds the result until the downstream side takes it.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int C_WIDTH   = 16,
  parameter int ACC_LEN   = 4,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [C_WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  localparam int ACC_WIDTH = C_WIDTH + clog2(ACC_LEN);
  localparam int CNT_WIDTH = clog2(ACC_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);

  state_t                      state_q;
  state_t                      state_d;
  logic                        running;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        accept;
  logic                        last_beat;
  logic [OUT_WIDTH-1:0]        rs_data;
  logic                        rs_sat;

  // running holds in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = running && (state_q == ACCUM) && !clr;
    out_valid = (state_q == HOLD);
    accept    = in_ready && in_valid;
    last_beat = accept && (cnt_q == LAST_CNT);
    acc_sum   = acc_q + ACC_WIDTH'($signed(in_data));
    state_d   = state_q;
    case (state_q)
      ACCUM:   if (last_beat) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  round_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_round_sat (
    .sum (acc_sum),
    .data(rs_data),
    .sat (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      running  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= 1'b1;
      if (state_q == ACCUM) begin
        if (clr) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else if (last_beat) begin
          acc_q    <= '0;
          cnt_q    <= '0;
          out_data <= rs_data;
          out_sat  <= rs_sat;
        end else if (accept) begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
